// File: rtl/i2c_target_rx.sv
// Write-only I2C target receiver: bus synchroniser, START/STOP detection, 7-bit address match, ACK drive, receive FIFO.
// Optional macro GENERAL_CALL_EN: when defined, address 7'h00 with W is also ACKed.
module i2c_target_rx #(
  parameter logic [6:0] TARGET_ADDR = 7'h55,
  parameter int         FIFO_DEPTH  = 4,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       start_det,
  output logic       stop_det,
  output logic       addr_match,
  output logic       busy,
  output logic       overflow,
  input  logic       overflow_clr
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronisers and edge/condition detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] scl_sync_reg;
  logic [SYNC_STAGES-1:0] sda_sync_reg;
  logic scl_s, sda_s;
  logic scl_prev_reg, sda_prev_reg;
  logic scl_rise, scl_fall, start_cond, stop_cond;
  logic scl_rise_reg, scl_fall_reg, start_reg, stop_reg, sda_bit_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_reg <= '1;
      sda_sync_reg <= '1;
    end else begin
      scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], scl_in};
      sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], sda_in};
    end
  end

  assign scl_s = scl_sync_reg[SYNC_STAGES-1];
  assign sda_s = sda_sync_reg[SYNC_STAGES-1];

  assign scl_rise   = scl_s & ~scl_prev_reg;
  assign scl_fall   = ~scl_s & scl_prev_reg;
  assign start_cond = scl_s & scl_prev_reg & sda_prev_reg & ~sda_s;
  assign stop_cond  = scl_s & scl_prev_reg & ~sda_prev_reg & sda_s;

  // The FSM acts on the registered events, so the data bit travels with them.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_prev_reg <= 1'b1;
      sda_prev_reg <= 1'b1;
      scl_rise_reg <= 1'b0;
      scl_fall_reg <= 1'b0;
      start_reg    <= 1'b0;
      stop_reg     <= 1'b0;
      sda_bit_reg  <= 1'b1;
    end else begin
      scl_prev_reg <= scl_s;
      sda_prev_reg <= sda_s;
      scl_rise_reg <= scl_rise;
      scl_fall_reg <= scl_fall;
      start_reg    <= start_cond;
      stop_reg     <= stop_cond;
      sda_bit_reg  <= sda_s;
    end
  end

  assign start_det = start_reg;
  assign stop_det  = stop_reg;

  // ---------------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       mem_reg [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [FIFO_DEPTH-1:0] entry_we;
  logic fifo_full, pop, push;
  logic [7:0] push_data;

  assign rx_valid  = (count_reg != '0);
  assign fifo_full = (count_reg == FULL_CNT);
  assign pop       = rx_valid & rx_ready;
  assign rx_data   = mem_reg[rd_ptr_reg];

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_we
      assign entry_we[gi] = push && (wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_reg[i] <= 8'h00;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        if (entry_we[i]) mem_reg[i] <= push_data;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol FSM
  // ---------------------------------------------------------------------------
  state_t     state_reg, state_next;
  logic [3:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] shift_reg, shift_next;
  logic       sda_oe_reg, sda_oe_next;
  logic       addr_match_reg, addr_match_next;
  logic       busy_reg, busy_next;
  logic       overflow_reg, overflow_set;
  logic       addr_ok;

`ifdef GENERAL_CALL_EN
  assign addr_ok = ~shift_reg[0] & ((shift_reg[7:1] == TARGET_ADDR) | (shift_reg[7:1] == 7'h00));
`else
  assign addr_ok = ~shift_reg[0] & (shift_reg[7:1] == TARGET_ADDR);
`endif

  assign push_data = shift_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= 4'd0;
      shift_reg      <= 8'h00;
      sda_oe_reg     <= 1'b0;
      addr_match_reg <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      sda_oe_reg     <= sda_oe_next;
      addr_match_reg <= addr_match_next;
      busy_reg       <= busy_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    sda_oe_next     = sda_oe_reg;
    addr_match_next = addr_match_reg;
    busy_next       = busy_reg;
    push            = 1'b0;
    overflow_set    = 1'b0;

    if (start_reg) begin
      state_next      = ADDR;
      bit_cnt_next    = 4'd0;
      busy_next       = 1'b1;
      addr_match_next = 1'b0;
      sda_oe_next     = 1'b0;
    end else if (stop_reg) begin
      state_next      = IDLE;
      busy_next       = 1'b0;
      addr_match_next = 1'b0;
      sda_oe_next     = 1'b0;
    end else begin
      case (state_reg)
        ADDR: begin
          if (scl_rise_reg && bit_cnt_reg < 4'd8) begin
            shift_next   = {shift_reg[6:0], sda_bit_reg};
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end else if (scl_fall_reg && bit_cnt_reg == 4'd8) begin
            if (addr_ok) begin
              sda_oe_next     = 1'b1;
              addr_match_next = 1'b1;
              state_next      = ADDR_ACK;
            end else begin
              sda_oe_next = 1'b0;
              state_next  = IGNORE;
            end
          end
        end
        ADDR_ACK, DATA_ACK: begin
          if (scl_fall_reg) begin
            sda_oe_next  = 1'b0;
            bit_cnt_next = 4'd0;
            state_next   = DATA;
          end
        end
        DATA: begin
          if (scl_rise_reg && bit_cnt_reg < 4'd8) begin
            shift_next   = {shift_reg[6:0], sda_bit_reg};
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end else if (scl_fall_reg && bit_cnt_reg == 4'd8) begin
            // A same-cycle pop frees a slot, so a full FIFO can still accept.
            if (!fifo_full || pop) begin
              push        = 1'b1;
              sda_oe_next = 1'b1;
              state_next  = DATA_ACK;
            end else begin
              overflow_set = 1'b1;
              sda_oe_next  = 1'b0;
              state_next   = IGNORE;
            end
          end
        end
        IGNORE:  sda_oe_next = 1'b0;
        default: sda_oe_next = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)               overflow_reg <= 1'b0;
    else if (overflow_set) overflow_reg <= 1'b1;
    else if (overflow_clr) overflow_reg <= 1'b0;
  end

  assign sda_oe     = sda_oe_reg;
  assign addr_match = addr_match_reg;
  assign busy       = busy_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: bit-banged 500 kHz master, queue-based receive model, randomized transfers.
module tb_i2c_target_rx;
  localparam int DEPTH = 4;
  localparam int QTR   = 25;   // quarter SCL period in clk cycles (2 us / 20 ns / 4)

  logic clk = 1'b0, rst = 1'b1;
  logic scl_m = 1'b1, sda_m = 1'b1;
  logic sda_line;
  logic sda_oe, rx_valid, rx_ready = 1'b0, start_det, stop_det;
  logic addr_match, busy, overflow, overflow_clr = 1'b0;
  logic [7:0] rx_data;

  int n_checks = 0, n_fail = 0;
  int start_cnt = 0, stop_cnt = 0;
  logic [7:0] model_q[$];
  bit model_ovf = 0;

  assign sda_line = sda_m & ~sda_oe;

  i2c_target_rx #(.TARGET_ADDR(7'h55), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_m), .sda_in(sda_line), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .start_det(start_det), .stop_det(stop_det), .addr_match(addr_match),
    .busy(busy), .overflow(overflow), .overflow_clr(overflow_clr)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (start_det) start_cnt++;
    if (stop_det)  stop_cnt++;
  end

  // Reference model: address rule and FIFO occupancy rule.
  function automatic bit addr_acks(input logic [7:0] a);
`ifdef GENERAL_CALL_EN
    return (a == 8'hAA) || (a == 8'h00);
`else
    return (a == 8'hAA);
`endif
  endfunction

  function automatic bit model_byte(input logic [7:0] b);
    if (model_q.size() < DEPTH) begin
      model_q.push_back(b);
      return 1'b1;
    end
    model_ovf = 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start;
    if (!scl_m) begin
      sda_m = 1'b1; wait_clks(QTR);
      scl_m = 1'b1; wait_clks(QTR);
    end
    sda_m = 1'b0; wait_clks(QTR);
    scl_m = 1'b0; wait_clks(QTR);
  endtask

  task automatic bus_stop;
    sda_m = 1'b0; wait_clks(QTR);
    scl_m = 1'b1; wait_clks(QTR);
    sda_m = 1'b1; wait_clks(2 * QTR);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    wait_clks(QTR);
    scl_m = 1'b1; wait_clks(2 * QTR);
    scl_m = 1'b0; wait_clks(QTR);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    sda_m = 1'b1; wait_clks(QTR);
    scl_m = 1'b1; wait_clks(QTR);
    ack = ~sda_line;
    wait_clks(QTR);
    scl_m = 1'b0; wait_clks(QTR);
  endtask

  task automatic drain(input string name);
    logic [7:0] exp;
    while (model_q.size() > 0) begin
      exp = model_q.pop_front();
      n_checks++;
      if (rx_valid !== 1'b1 || rx_data !== exp) begin
        n_fail++;
        $display("FAIL %s drain: rx_valid=%b rx_data=%h, required 1 %h", name, rx_valid, rx_data, exp);
      end else $display("%s drain byte %h", name, rx_data);
      rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;
    end
    n_checks++;
    if (rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s empty: rx_valid=%b, required 0", name, rx_valid);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; wait_clks(5); rst = 1'b0; wait_clks(1);
    n_checks++;
    if ({sda_oe, rx_valid, rx_data, start_det, stop_det, addr_match, busy, overflow} !== 15'h0) begin
      n_fail++;
      $display("FAIL reset outputs: oe=%b v=%b d=%h st=%b sp=%b am=%b busy=%b ovf=%b, required all 0",
               sda_oe, rx_valid, rx_data, start_det, stop_det, addr_match, busy, overflow);
    end else $display("reset: outputs idle");
  endtask

  task automatic test_basic_write;
    logic ack;
    int s0 = start_cnt, p0 = stop_cnt;
    bus_start;
    send_byte(8'hAA, ack);
    n_checks++;
    if (ack !== 1'b1 || addr_match !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic addr: ack=%b am=%b busy=%b, required 1 1 1", ack, addr_match, busy);
    end else $display("basic: addr 0xAA ACKed");
    send_byte(8'h55, ack);
    n_checks++;
    if (ack !== model_byte(8'h55)) begin
      n_fail++;
      $display("FAIL basic data ack: ack=%b, required 1", ack);
    end else $display("basic: data 0x55 ACKed");
    bus_stop;
    n_checks++;
    if (start_cnt - s0 != 1 || stop_cnt - p0 != 1 || busy !== 1'b0 || addr_match !== 1'b0) begin
      n_fail++;
      $display("FAIL basic events: starts=%0d stops=%0d busy=%b am=%b, required 1 1 0 0",
               start_cnt - s0, stop_cnt - p0, busy, addr_match);
    end else $display("basic: one START, one STOP, bus idle");
    drain("basic");
  endtask

  task automatic test_addr_mismatch;
    logic ack;
    bus_start;
    send_byte(8'hAC, ack);
    n_checks++;
    if (ack !== 1'b0 || addr_match !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mismatch addr: ack=%b am=%b busy=%b, required 0 0 1", ack, addr_match, busy);
    end else $display("mismatch: addr 0xAC NACKed");
    send_byte(8'h12, ack);
    n_checks++;
    if (ack !== 1'b0 || rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mismatch ignore: ack=%b rx_valid=%b, required 0 0", ack, rx_valid);
    end else $display("mismatch: following byte ignored");
    bus_stop;
  endtask

  task automatic test_read_nack;
    logic ack;
    bus_start;
    send_byte(8'hAB, ack);
    bus_stop;
    n_checks++;
    if (ack !== 1'b0 || rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL read nack: ack=%b rx_valid=%b, required 0 0", ack, rx_valid);
    end else $display("read: 0xAB NACKed, no push");
  endtask

  task automatic test_overflow;
    logic ack, exp;
    bus_start;
    send_byte(8'hAA, ack);
    for (int i = 1; i <= 5; i++) begin
      send_byte(8'(i), ack);
      exp = model_byte(8'(i));
      n_checks++;
      if (ack !== exp) begin
        n_fail++;
        $display("FAIL overflow ack byte %0d: ack=%b, required %b", i, ack, exp);
      end else $display("overflow: byte %0d ack=%b", i, ack);
    end
    bus_stop;
    n_checks++;
    if (overflow !== model_ovf) begin
      n_fail++;
      $display("FAIL overflow flag: overflow=%b, required %b", overflow, model_ovf);
    end
    drain("overflow");
    overflow_clr = 1'b1; wait_clks(1); overflow_clr = 1'b0; wait_clks(1);
    model_ovf = 1'b0;
    n_checks++;
    if (overflow !== model_ovf) begin
      n_fail++;
      $display("FAIL overflow clear: overflow=%b, required 0", overflow);
    end else $display("overflow: cleared");
  endtask

  task automatic test_repeated_start;
    logic ack;
    int s0 = start_cnt, p0 = stop_cnt;
    bus_start;
    send_byte(8'hAA, ack);
    send_byte(8'h11, ack);
    void'(model_byte(8'h11));
    bus_start;
    n_checks++;
    if (addr_match !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rstart state: am=%b busy=%b, required 0 1", addr_match, busy);
    end
    send_byte(8'hAA, ack);
    send_byte(8'h22, ack);
    void'(model_byte(8'h22));
    bus_stop;
    n_checks++;
    if (start_cnt - s0 != 2 || stop_cnt - p0 != 1) begin
      n_fail++;
      $display("FAIL rstart events: starts=%0d stops=%0d, required 2 1", start_cnt - s0, stop_cnt - p0);
    end else $display("rstart: two STARTs, one STOP");
    drain("rstart");
  endtask

  task automatic test_reset_mid;
    logic ack;
    bus_start;
    send_byte(8'hAA, ack);
    for (int i = 7; i >= 0; i--) write_bit(1'(8'h77 >> i));
    sda_m = 1'b1;
    n_checks++;
    if (sda_oe !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst pre: sda_oe=%b, required 1", sda_oe);
    end
    rst = 1'b1; wait_clks(1);
    n_checks++;
    if (sda_oe !== 1'b0 || rx_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst: sda_oe=%b rx_valid=%b busy=%b, required 0 0 0", sda_oe, rx_valid, busy);
    end else $display("midrst: SDA released, FIFO flushed");
    rst = 1'b0;
    scl_m = 1'b1; wait_clks(4 * QTR);
    bus_start;
    send_byte(8'hAA, ack);
    send_byte(8'h33, ack);
    n_checks++;
    if (ack !== model_byte(8'h33)) begin
      n_fail++;
      $display("FAIL midrst recover ack: ack=%b, required 1", ack);
    end
    bus_stop;
    drain("midrst");
  endtask

  task automatic test_random;
    logic ack, exp;
    logic [7:0] addr, d;
    int nb;
    for (int t = 0; t < 6; t++) begin
      addr = ($urandom_range(0, 2) != 0) ? 8'hAA : 8'($urandom_range(0, 255));
      nb = $urandom_range(1, 3);
      bus_start;
      send_byte(addr, ack);
      exp = addr_acks(addr);
      n_checks++;
      if (ack !== exp) begin
        n_fail++;
        $display("FAIL random %0d addr %h: ack=%b, required %b", t, addr, ack, exp);
      end else $display("random %0d: addr %h ack=%b", t, addr, ack);
      if (exp) begin
        for (int k = 0; k < nb; k++) begin
          d = 8'($urandom_range(0, 255));
          send_byte(d, ack);
          exp = model_byte(d);
          n_checks++;
          if (ack !== exp) begin
            n_fail++;
            $display("FAIL random %0d data %h: ack=%b, required %b", t, d, ack, exp);
          end else $display("random %0d: data %h ack=%b", t, d, ack);
        end
      end
      bus_stop;
      drain($sformatf("random%0d", t));
    end
  endtask

  initial begin
    test_reset;
    test_basic_write;
    test_addr_mismatch;
    test_read_nack;
    test_overflow;
    test_repeated_start;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
